// File: rtl/int8_fc_stream.sv
// int8_fc_stream: streamed INT8 fully-connected layer.
// Each accepted input element updates all OUT neuron accumulators in parallel.
// At the last element every lane latches its requantised int8 result. The
// results are then emitted one neuron per handshake from a registered m_data.

// Per-neuron lane: weight row, bias, accumulator and requantisation.
module int8_fc_lane #(
  parameter int IN    = 8,
  parameter int SHIFT = 7,
  parameter int ACC_W = 32,
  parameter int AW    = 5,
  parameter int IW    = 3,
  parameter int LANE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic             cfg_sel,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [ACC_W-1:0] cfg_data,
  input  logic [IW-1:0]    idx,
  input  logic [7:0]       x,
  input  logic             acc_en,
  input  logic             acc_last,
  output logic [7:0]       res_d,
  output logic [7:0]       res_q
);
  localparam logic [31:0] BASE = 32'(LANE * IN);
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  // Weights and bias power up at zero and survive rst.
  logic [7:0]              w_mem [IN] = '{default: '0};
  logic [ACC_W-1:0]        bias = '0;
  logic [ACC_W-1:0]        acc, acc_nx, t;
  logic signed [15:0]      prod;
  logic signed [ACC_W:0]   tr, r_sh;
  logic [31:0]             a32;
  logic                    w_hit, b_hit, pos, neg;

  assign a32   = 32'(cfg_addr);
  assign w_hit = cfg_en & ~cfg_sel & (a32 >= BASE) & (a32 < BASE + 32'(IN));
  assign b_hit = cfg_en &  cfg_sel & (a32 == 32'(LANE));

  // Accumulate, add bias, round half up, arithmetic shift, saturate.
  always_comb begin
    prod   = $signed(x) * $signed(w_mem[idx]);
    acc_nx = acc + {{(ACC_W-16){prod[15]}}, prod};
    t      = acc_nx + bias;
    tr     = $signed({t[ACC_W-1], t}) + RND;
    r_sh   = tr >>> SHIFT;
    pos    = ~r_sh[ACC_W] & (|r_sh[ACC_W-1:7]);
    neg    =  r_sh[ACC_W] & ~(&r_sh[ACC_W-1:7]);
    res_d  = pos ? 8'h7F : (neg ? 8'h80 : r_sh[7:0]);
  end

  // Accumulator clears once the vector's result is latched; abort on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      res_q <= '0;
    end else if (acc_en) begin
      acc <= acc_last ? '0 : acc_nx;
      if (acc_last) res_q <= res_d;
    end
  end

  // Config writes; reads of the same edge see the old value.
  always_ff @(posedge clk) begin
    if (w_hit) w_mem[IW'(a32 - BASE)] <= cfg_data[7:0];
    if (b_hit) bias <= cfg_data;
  end
endmodule

module int8_fc_stream #(
  parameter int IN    = 8,
  parameter int OUT   = 4,
  parameter int SHIFT = 7,
  parameter int ACC_W = 32,
  localparam int AW   = (OUT*IN > 1) ? $clog2(OUT*IN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [ACC_W-1:0] cfg_data,
  output logic             cfg_ready,
  input  logic             relu_en,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  input  logic             m_ready
);
  localparam int IW = (IN  > 1) ? $clog2(IN)  : 1;
  localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;

  typedef enum logic {ACC, EMIT} state_t;
  state_t state, state_nx;

  logic [IW-1:0]            idx;
  logic [OW-1:0]            oidx, onx;
  logic                     s_hs, in_last, m_hs;
  logic [OUT-1:0][7:0]      res_d, res_q;

  function automatic logic [7:0] relu(input logic [7:0] v, input logic en);
    return (en && v[7]) ? 8'h00 : v;
  endfunction

  assign s_hs    = s_valid & s_ready;
  assign in_last = s_hs & (idx == IW'(IN - 1));
  assign m_hs    = m_valid & m_ready;
  assign onx     = oidx + OW'(1);

  for (genvar j = 0; j < OUT; j++) begin : g_lane
    int8_fc_lane #(.IN(IN), .SHIFT(SHIFT), .ACC_W(ACC_W), .AW(AW), .IW(IW), .LANE(j)) u_lane (
      .clk(clk), .rst(rst),
      .cfg_en(cfg_we & cfg_ready), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .idx(idx), .x(s_data), .acc_en(s_hs), .acc_last(in_last),
      .res_d(res_d[j]), .res_q(res_q[j])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nx;
  end

  // Next state and handshake outputs, all decoded from registers.
  always_comb begin
    state_nx  = state;
    s_ready   = (state == ACC);
    m_valid   = (state == EMIT);
    m_last    = (state == EMIT) && (oidx == OW'(OUT - 1));
    cfg_ready = (state == ACC) && (idx == '0);
    case (state)
      ACC:  if (s_valid && idx == IW'(IN - 1)) state_nx = EMIT;
      EMIT: if (m_ready && m_last)             state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  // Element/neuron indices and the registered output word; relu sampled on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      oidx   <= '0;
      m_data <= '0;
    end else begin
      if (s_hs) idx <= in_last ? '0 : idx + IW'(1);
      if (in_last) begin
        oidx   <= '0;
        m_data <= relu(res_d[0], relu_en);
      end else if (m_hs) begin
        if (m_last) begin
          oidx <= '0;
        end else begin
          oidx   <= onx;
          m_data <= relu(res_q[onx], relu_en);
        end
      end
    end
  end
endmodule

// File: tb/tb_int8_fc_stream.sv
// Directed bench for int8_fc_stream: vector table plus hand-written sequences.
module tb_int8_fc_stream;
  localparam int IN = 8, OUT = 4;

  logic        clk = 0, rst = 1;
  logic        cfg_we = 0, cfg_sel = 0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ready, relu_en = 0;
  logic        s_valid = 0, s_ready;
  logic [7:0]  s_data = '0;
  logic        m_valid, m_last, m_ready = 1;
  logic [7:0]  m_data;

  int checks = 0, errors = 0;
  int cur_cfg = 3;
  int bdef[4] = '{1280, -2560, 640, 0};

  int8_fc_stream dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .relu_en(relu_en),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      cfg;   // 0 default, 1 all 127, 2 single W[0][0]=64, 3 untouched
    logic            relu;
    logic [7:0][7:0] x;
    logic [3:0][7:0] e;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_wr(input logic sel, input int addr, input int data);
    int n = 0;
    @(negedge clk);
    s_valid = 0;
    while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
    if (!cfg_ready) chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_we = 1; cfg_sel = sel; cfg_addr = 5'(addr); cfg_data = 32'(data);
    @(posedge clk); #1 cfg_we = 0;
  endtask

  task automatic load_cfg(input int id);
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++)
        cfg_wr(0, o*IN + i, id == 0 ? (o+1)*(i-3) : id == 1 ? 127 : (o == 0 && i == 0) ? 64 : 0);
    for (int o = 0; o < OUT; o++) cfg_wr(1, o, id == 0 ? bdef[o] : 0);
    cur_cfg = id;
  endtask

  // Cycle-by-cycle driver: inputs set and registered outputs sampled on negedge.
  task automatic run_vec(input string nm, input logic [7:0][7:0] xv, input logic [3:0][7:0] ev,
                         input logic relu, input bit gaps, input int stall_n, input int stall_len,
                         input int first, input bit chk_period);
    int ni = first, no = 0, cyc = 0, st = 0;
    bit pstall = 0, done = 0;
    logic [7:0] pd = '0;
    logic pl = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      relu_en = relu;
      if (ni < IN) begin s_valid = gaps ? (cyc % 2 == 0) : 1'b1; s_data = xv[ni]; end
      else begin s_valid = 1; s_data = 8'd77; end
      m_ready = !(no == stall_n && st < stall_len);
      chk({nm, "_s_ready"}, 32'(s_ready), 32'(!m_valid));
      if (m_valid) begin
        if (pstall) begin
          chk({nm, "_hold_data"}, 32'(m_data), 32'(pd));
          chk({nm, "_hold_last"}, 32'(m_last), 32'(pl));
        end
        if (m_ready) begin
          chk($sformatf("%s_y%0d", nm, no), 32'(m_data), 32'(ev[no]));
          chk($sformatf("%s_last%0d", nm, no), 32'(m_last), 32'(no == OUT-1));
          if (no == OUT-1) done = 1;
          no++; pstall = 0;
        end else begin
          st++; pstall = 1; pd = m_data; pl = m_last;
        end
      end else if (s_valid && s_ready) ni++;
      cyc++;
    end
    if (!done) chk({nm, "_timeout"}, 32'(no), 32'(OUT));
    if (chk_period) chk({nm, "_period"}, 32'(cyc), 32'(IN + OUT - first));
  endtask

  initial begin
    vecs[0] = '{cfg: 2'd3, relu: 1'b0, x: {8{8'h01}}, e: 32'h0};
    vecs[1] = '{cfg: 2'd0, relu: 1'b0, x: {8{8'h01}}, e: {8'h00, 8'h05, 8'hEC, 8'h0A}};
    vecs[2] = '{cfg: 2'd0, relu: 1'b1, x: {8{8'h01}}, e: {8'h00, 8'h05, 8'h00, 8'h0A}};
    vecs[3] = '{cfg: 2'd0, relu: 1'b0, x: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                e: {8'h02, 8'h06, 8'hED, 8'h0A}};
    vecs[4] = '{cfg: 2'd1, relu: 1'b0, x: {8{8'h7F}}, e: {4{8'h7F}}};
    vecs[5] = '{cfg: 2'd1, relu: 1'b0, x: {8{8'h80}}, e: {4{8'h80}}};
    vecs[6] = '{cfg: 2'd1, relu: 1'b1, x: {8{8'h80}}, e: 32'h0};
    vecs[7] = '{cfg: 2'd2, relu: 1'b0, x: {56'h0, 8'h01}, e: {24'h0, 8'h01}};
    vecs[8] = '{cfg: 2'd2, relu: 1'b0, x: {56'h0, 8'hFF}, e: 32'h0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);

    // Table vectors.
    for (int k = 0; k < 9; k++) begin
      if (int'(vecs[k].cfg) != cur_cfg && vecs[k].cfg != 2'd3) load_cfg(int'(vecs[k].cfg));
      run_vec($sformatf("vec%0d", k), vecs[k].x, vecs[k].e, vecs[k].relu, 0, -1, 0, 0, 1);
    end

    // Input gaps plus 5-cycle stall on neuron 1.
    load_cfg(0);
    run_vec("bp", {8{8'h01}}, {8'h00, 8'h05, 8'hEC, 8'h0A}, 0, 1, 1, 5, 0, 0);

    // Back-to-back vectors with s_valid held high.
    run_vec("b2b_a", {8{8'h01}}, {8'h00, 8'h05, 8'hEC, 8'h0A}, 0, 0, -1, 0, 0, 1);
    run_vec("b2b_b", {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
            {8'h02, 8'h06, 8'hED, 8'h0A}, 0, 0, -1, 0, 0, 1);

    // Reset after 3 elements: no output, weights retained.
    @(negedge clk);
    s_valid = 1; s_data = 8'h05;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_cfg_locked", 32'(cfg_ready), 0);
    s_valid = 0; rst = 1;
    @(negedge clk) rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_m_valid", 32'(m_valid), 0);
      chk("mid_cfg_ready", 32'(cfg_ready), 1);
    end
    run_vec("mid_after", {8{8'h01}}, {8'h00, 8'h05, 8'hEC, 8'h0A}, 0, 0, -1, 0, 0, 1);

    // Config lockout at idx 2.
    @(negedge clk);
    s_valid = 1; s_data = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_valid = 0; cfg_we = 1; cfg_sel = 0; cfg_addr = 5'd0; cfg_data = 32'd99;
    chk("lock_cfg_ready", 32'(cfg_ready), 0);
    @(posedge clk); #1 cfg_we = 0;
    run_vec("lock_cur", {8{8'h01}}, {8'h00, 8'h05, 8'hEC, 8'h0A}, 0, 0, -1, 0, 2, 1);
    run_vec("lock_next", {56'h0, 8'h40}, {8'hFA, 8'h01, 8'hE9, 8'h09}, 0, 0, -1, 0, 0, 1);

    @(negedge clk) s_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/int8_fc_stream.md
# int8_fc_stream

Parametrised INT8 fully-connected layer: IN inputs, OUT outputs, with run-time loadable weights and biases, streamed input and output, ReLU mode, and backpressure. Each accepted input element updates all OUT accumulators in parallel. Results are bias-added, round-shifted, optionally ReLU'd, and saturated to int8, then emitted one neuron per handshake. It sits between int8 stream producers and consumers in the MLP datapath and is the layer primitive for multi-layer chaining.

## Interface
- IN, 8: input vector length (≥1)
- OUT, 4: output neurons (≥1)
- SHIFT, 7: requant right-shift (0..30)
- ACC_W, 32: accumulator/bias width (≥24)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = weight, 1 = bias
- cfg_addr  in  $clog2(OUT*IN)  weight addr o*IN+i; bias addr o
- cfg_data  in  ACC_W  bias value; weight uses [7:0]
- cfg_ready  out  1  config writes accepted this cycle
- relu_en  in  1  clamp negative results to 0
- s_valid  in  1  input element valid
- s_data  in  8  signed int8 input element
- s_ready  out  1  input element accepted when s_valid&s_ready
- m_valid  out  1  output element valid
- m_data  out  8  signed int8 result
- m_last  out  1  marks neuron OUT-1
- m_ready  in  1  downstream accepts

## Operation
- States:
  - ACC: s_ready=1, m_valid=0.
  - EMIT: s_ready=0, m_valid=1.
- ACC handshake with element index idx: acc[j] += s_data*W[j][idx] for all j (signed 16-bit product, sign-extended). Then idx++.
- The handshake at idx==IN-1 moves the block to EMIT with oidx=0.
- EMIT output for neuron oidx:
  - t = acc[oidx] + B[oidx] (ACC_W, wraps modulo 2^ACC_W).
  - SHIFT>0: r = (t + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round half up). SHIFT=0: r = t.
  - relu_en: r = max(r, 0).
  - m_data = sat(r) to [-128, 127].
  - m_last = (oidx==OUT-1).
- EMIT advance: each m_valid&m_ready increments oidx.
- EMIT completion: handshake with m_last clears all acc, sets idx=0, and returns to ACC.
- relu_en is sampled per output element.
- Config path:
  - cfg_ready=1 only in ACC with idx==0.
  - cfg_we with cfg_ready writes W or B at the next edge.
  - cfg_we without cfg_ready is ignored.
  - Out-of-range addresses are ignored.
- W and B power up at zero. rst does not clear them.
- s_valid in EMIT is ignored and nothing is consumed.
- m_data, m_valid, and m_last derive from registers only; there is no combinational path from inputs.

## Timing
- Reset values: state ACC, idx=0, oidx=0, acc=0, m_valid=0, m_last=0, m_data=0.
- s_ready=1 from the first cycle after rst deasserts. cfg_ready=1 at the same time.
- The last input handshake at edge k produces m_valid=1 with neuron 0 in cycle k+1.
- The final output handshake at edge e produces s_ready=1 in cycle e+1.
- Minimum vector period: IN+OUT cycles. Input and output phases do not overlap.
- While m_valid=1 and m_ready=0, m_data and m_last hold stable.
- rst mid-vector or mid-emit aborts the current vector with no partial output. The next vector starts clean.
- The cfg_ready window opens in the same cycle that s_ready reopens after emit. A cfg write and the first input handshake may coincide. The write then lands at that edge, and the accepted element uses the old value.

## Test plan
- Default config:
  - Stimulus: load W[o][i]=(o+1)*(i-3) and B={1280,-2560,640,0}, then x=8×1.
  - Expected: m_data=10,-20,5,0 with m_last on the 4th. With relu_en=1: 10,0,5,0.
- Saturation and rounding:
  - Stimulus: all W=127, B=0, x=8×127. Expected: 127.
  - Stimulus: x=8×-128. Expected: -128.
  - Stimulus: single W[0][0]=64, x0=1, rest 0. Expected: y0=1 (half rounds up).
  - Stimulus: x0=-1. Expected: y0=0.
- Backpressure and gaps:
  - Stimulus: s_valid toggling 1/0 during input, and m_ready low 5 cycles on neuron 1.
  - Expected: only handshakes counted, m_data held stable, s_ready=0 throughout EMIT, and output order 0..3 unchanged.
- Back-to-back vectors:
  - Stimulus: s_valid held high.
  - Expected: second vector accepted starting the cycle after the m_last handshake, results independent of the first, and period 12 cycles with m_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst after 3 elements.
  - Expected: m_valid stays 0 and weights are retained. The next full vector yields the default-config result exactly.
- Config lockout:
  - Stimulus: cfg_we writing W[0][0]=99 while idx=2.
  - Expected: cfg_ready=0, the write is ignored, and the result is unchanged.
